rotate_arbiter: RTL and testbench



---
 rtl/rotate_arbiter.sv | 107 ++++++++++
 tb/tb_rotate_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one 32-bit left/right barrel rotator among NUM_REQ requesters.
// Optional macro ROT_ARB_STATS_EN adds a saturating accept counter (op_count) with a synchronous clear (stats_clr).
module rotate_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_dir,
    input  logic [5*NUM_REQ-1:0]  req_shift,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id
`ifdef ROT_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           op_count
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            slot_free;
    logic            fire;
    logic [31:0]     sel_data;
    logic            sel_dir;
    logic [4:0]      sel_shift;
    logic [31:0]     rot_data;
    int              cand;

    // The complementary amount is 6 bits wide so a shift of 0 becomes 32 and shifts out to zero.
    function automatic logic [31:0] rotate(input logic [31:0] d, input logic dir, input logic [4:0] s);
        logic [5:0] comp;
        comp = 6'd32 - {1'b0, s};
        if (dir)
            rotate = (d >> s) | (d << comp);
        else
            rotate = (d << s) | (d >> comp);
    endfunction

    // Keep req_ready low while reset is held, even if requesters are already valid.
    assign slot_free = rst_n & ((state == EMPTY) | resp_ready);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = ID_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found)
            req_ready[winner] = slot_free;
    end

    assign fire      = found & slot_free;
    assign sel_data  = req_data[32*int'(winner) +: 32];
    assign sel_dir   = req_dir[winner];
    assign sel_shift = req_shift[5*int'(winner) +: 5];
    assign rot_data  = rotate(sel_data, sel_dir, sel_shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            rr_ptr     <= '0;
        end else if (fire) begin
            state      <= FULL;
            resp_valid <= 1'b1;
            resp_data  <= rot_data;
            resp_id    <= winner;
            rr_ptr     <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end else if (state == FULL && resp_ready) begin
            state      <= EMPTY;
            resp_valid <= 1'b0;
        end
    end

`ifdef ROT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (stats_clr)
            op_count <= '0;
        else if (fire && op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed self-checking bench for rotate_arbiter: rotations, round-robin order, backpressure, async reset.
module tb_rotate_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_dir;
    logic [5*NUM_REQ-1:0]  req_shift;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
`ifdef ROT_ARB_STATS_EN
    logic                  stats_clr;
    logic [15:0]           op_count;
`endif

    int checks = 0;
    int errors = 0;

    rotate_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_dir    (req_dir),
        .req_shift  (req_shift),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef ROT_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .op_count   (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setReq(input int idx, input logic [31:0] d, input logic dr, input logic [4:0] s);
        req_data[32*idx +: 32] = d;
        req_dir[idx]           = dr;
        req_shift[5*idx +: 5]  = s;
    endtask

    // Single requester transaction: ready in the same cycle, result one cycle later.
    task automatic applyStimulus(input int idx, input logic [31:0] d, input logic dr, input logic [4:0] s,
                                 input logic [31:0] exp, input string tag);
        setReq(idx, d, dr, s);
        req_valid[idx] = 1'b1;
        #1;
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        checkOutput({tag, "_valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, "_data"}, resp_data, exp);
        checkOutput({tag, "_id"}, 32'(resp_id), 32'(idx));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_dir    = '0;
        req_shift  = '0;
        resp_ready = 1'b0;
`ifdef ROT_ARB_STATS_EN
        stats_clr  = 1'b0;
`endif
        #3;
        checkOutput("rst_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_data", resp_data, 32'd0);
        checkOutput("rst_id", 32'(resp_id), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        resp_ready = 1'b1;
        applyStimulus(0, 32'h8000_0001, 1'b1, 5'd1, 32'hC000_0000, "rotr1");
        applyStimulus(1, 32'h1234_5678, 1'b0, 5'd4, 32'h2345_6781, "rotl4");
        applyStimulus(2, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hDEAD_BEEF, "rotr0");
        applyStimulus(3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'hDEAD_BEEF, "rotl0");
        applyStimulus(0, 32'h0000_0001, 1'b0, 5'd31, 32'h8000_0000, "rotl31");
        applyStimulus(3, 32'hF000_0000, 1'b1, 5'd4, 32'h0F00_0000, "rotr4");

        // Pointer is back at 0; all requesters stay valid and must be served in order.
        setReq(0, 32'd1, 1'b0, 5'd0);
        setReq(1, 32'd2, 1'b0, 5'd1);
        setReq(2, 32'd3, 1'b0, 5'd2);
        setReq(3, 32'd4, 1'b0, 5'd3);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            @(posedge clk);
            #1;
            checkOutput("rr_valid", 32'(resp_valid), 32'd1);
            checkOutput("rr_id", 32'(resp_id), 32'(k % 4));
            checkOutput("rr_data", resp_data, 32'((k % 4 + 1) << (k % 4)));
        end

        resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("bp_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_data", resp_data, 32'd4);
            checkOutput("bp_id", 32'(resp_id), 32'd1);
            @(posedge clk);
        end
        #1;
        resp_ready = 1'b1;
        #1;
        checkOutput("bp_rel_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        checkOutput("bp_rel_id", 32'(resp_id), 32'd2);
        checkOutput("bp_rel_data", resp_data, 32'd12);

        resp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(resp_valid), 32'd0);
        checkOutput("arst_data", resp_data, 32'd0);
        checkOutput("arst_id", 32'(resp_id), 32'd0);
        #2;
        rst_n = 1'b1;
        setReq(2, 32'h0000_FFFF, 1'b1, 5'd8);
        setReq(3, 32'hA5A5_A5A5, 1'b0, 5'd1);
        req_valid  = 4'b1100;
        resp_ready = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        checkOutput("post_rst_id", 32'(resp_id), 32'd2);
        checkOutput("post_rst_data", resp_data, 32'hFF00_00FF);
        #1;
        checkOutput("post_rst_ready3", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1;
        req_valid = '0;
        checkOutput("post_rst_id3", 32'(resp_id), 32'd3);
        checkOutput("post_rst_data3", resp_data, 32'h4B4B_4B4B);
        @(posedge clk);
        #1;
        checkOutput("drain_valid", 32'(resp_valid), 32'd0);

`ifdef ROT_ARB_STATS_EN
        checkOutput("stats_count", 32'(op_count), 32'd2);
        setReq(0, 32'd1, 1'b0, 5'd0);
        req_valid[0] = 1'b1;
        stats_clr    = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        stats_clr    = 1'b0;
        checkOutput("stats_clr", 32'(op_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
